// File: rtl/master_port_pkg.sv
// master_port_pkg
//   Shared definitions for the serial-bus master port: FSM state encodings,
//   and helper functions that derive field widths, chunk counts and the
//   chunk-counter width from the module parameters.
package master_port_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_LOAD  = 3'd1;
  localparam state_t S_REQ   = 3'd2;
  localparam state_t S_SADDR = 3'd3;
  localparam state_t S_WAIT  = 3'd4;
  localparam state_t S_ADDR  = 3'd5;
  localparam state_t S_WDATA = 3'd6;
  localparam state_t S_RDATA = 3'd7;

  // Width of the slave-device field (upper address bits).
  function automatic int sdw_f(input int addr_w, input int smw);
    return addr_w - smw;
  endfunction

  // Number of serial cycles needed to move a field of width w.
  function automatic int ch_f(input int w, input int lanes);
    return w / lanes;
  endfunction

  // One counter is shared by every phase, so it must index the longest one.
  function automatic int cntw_f(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m <= 1) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/master_port_burst_wbuf.sv
// master_wbuf
//   MAX_BURST x DATA_WIDTH write-data buffer. Filled sequentially while the
//   port collects write words; read randomly by beat index during transfer.
//   clk, rst : clock, asynchronous active-high reset (pointer only)
//   clr      : rewind the write pointer (new request accepted)
//   we/wdata : store one word at the write pointer and advance it
//   wptr     : current write pointer
//   rd_idx   : beat index to read; rdata is combinational
module master_wbuf
  import master_port_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4,
  parameter int LENW       = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [LENW-1:0]       rd_idx,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [LENW-1:0]       wptr
);

  logic [DATA_WIDTH-1:0] mem [MAX_BURST];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
    end else if (clr) begin
      wptr <= '0;
    end else if (we) begin
      wptr <= wptr + LENW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr] <= wdata;
  end

  assign rdata = mem[rd_idx];

endmodule

// File: rtl/master_port_burst.sv
// master_port_burst
//   Serial-bus master port. Accepts single/burst read or write requests,
//   buffers write data, arbitrates for the bus and shifts each beat out as
//   device field, ack wait, memory field, then write data (or collects read
//   data). The bus is held for a whole burst; an ack timeout aborts it.
//   Request side : dvalid/dready, daddr, dmode, dlen, dwdata/dwvalid/dwready,
//                  drdata/drvalid, derr
//   Bus side     : mwdata, mrdata, mmode, mvalid, svalid, mbreq, mbgrant, ack
module master_port_burst
  import master_port_pkg::*;
#(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 8,
  parameter int SLAVE_MEM_ADDR_WIDTH = 12,
  parameter int LANES                = 1,
  parameter int MAX_BURST            = 4,
  parameter int ACK_TIMEOUT          = 16,
  localparam int LENW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dvalid,
  output logic                  dready,
  input  logic [ADDR_WIDTH-1:0] daddr,
  input  logic                  dmode,
  input  logic [LENW-1:0]       dlen,
  input  logic [DATA_WIDTH-1:0] dwdata,
  input  logic                  dwvalid,
  output logic                  dwready,
  output logic [DATA_WIDTH-1:0] drdata,
  output logic                  drvalid,
  output logic                  derr,
  output logic [LANES-1:0]      mwdata,
  input  logic [LANES-1:0]      mrdata,
  output logic                  mmode,
  output logic                  mvalid,
  input  logic                  svalid,
  output logic                  mbreq,
  input  logic                  mbgrant,
  input  logic                  ack
);

  localparam int SMW    = SLAVE_MEM_ADDR_WIDTH;
  localparam int SDW    = sdw_f(ADDR_WIDTH, SMW);
  localparam int SDW_CH = ch_f(SDW, LANES);
  localparam int SMW_CH = ch_f(SMW, LANES);
  localparam int DW_CH  = ch_f(DATA_WIDTH, LANES);
  localparam int CW     = cntw_f(SDW_CH, SMW_CH, DW_CH);
  localparam int TW     = $clog2(ACK_TIMEOUT) + 1;

  localparam logic [CW-1:0]   SDW_LAST = CW'(SDW_CH - 1);
  localparam logic [CW-1:0]   SMW_LAST = CW'(SMW_CH - 1);
  localparam logic [CW-1:0]   DW_LAST  = CW'(DW_CH - 1);
  localparam logic [TW-1:0]   T_LAST   = TW'(ACK_TIMEOUT - 1);
  localparam logic [LENW-1:0] LEN_MAX  = LENW'(MAX_BURST - 1);

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  mode;
  logic [LENW-1:0]       len, len_in, beat, wptr;
  logic [CW-1:0]         cnt;
  logic [TW-1:0]         tcnt;
  logic [DATA_WIDTH-1:0] rdreg, rd_next, wword;
  logic [SDW-1:0]        dev;
  logic [SMW-1:0]        memf;
  logic [LANES-1:0]      chunk_dev, chunk_mem, chunk_dat;
  logic                  hs, wr_hs, beat_done;
  int                    base;

  // dlen can only exceed the burst limit when MAX_BURST is not a power of two.
  generate
    if ((2 ** LENW) > MAX_BURST) begin : g_clamp
      assign len_in = (dlen > LEN_MAX) ? LEN_MAX : dlen;
    end else begin : g_noclamp
      assign len_in = dlen;
    end
  endgenerate

  assign dready  = (state == S_IDLE);
  assign dwready = (state == S_LOAD);
  assign mbreq   = (state != S_IDLE) && (state != S_LOAD);
  assign mmode   = mode;
  assign hs      = dvalid && dready;
  assign wr_hs   = dwvalid && dwready;

  assign dev       = addr[ADDR_WIDTH-1:SMW];
  assign memf      = addr[SMW-1:0];
  assign base      = int'(cnt) * LANES;
  assign chunk_dev = dev[base +: LANES];
  assign chunk_mem = memf[base +: LANES];
  assign chunk_dat = wword[base +: LANES];

  assign beat_done = ((state == S_WDATA) && (cnt == DW_LAST)) ||
                     ((state == S_RDATA) && svalid && (cnt == DW_LAST));

  always_comb begin
    rd_next = rdreg;
    rd_next[base +: LANES] = mrdata;
  end

  master_wbuf #(
    .DATA_WIDTH (DATA_WIDTH),
    .MAX_BURST  (MAX_BURST),
    .LENW       (LENW)
  ) u_wbuf (
    .clk    (clk),
    .rst    (rst),
    .clr    (hs),
    .we     (wr_hs),
    .wdata  (dwdata),
    .rd_idx (beat),
    .rdata  (wword),
    .wptr   (wptr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      mode    <= 1'b0;
      beat    <= '0;
      cnt     <= '0;
      tcnt    <= '0;
      mwdata  <= '0;
      mvalid  <= 1'b0;
      drdata  <= '0;
      drvalid <= 1'b0;
      derr    <= 1'b0;
    end else begin
      drvalid <= 1'b0;
      derr    <= 1'b0;
      mvalid  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (hs) begin
            mode  <= dmode;
            beat  <= '0;
            cnt   <= '0;
            state <= dmode ? S_LOAD : S_REQ;
          end
        end
        S_LOAD: begin
          if (wr_hs && (wptr == len)) state <= S_REQ;
        end
        S_REQ: begin
          if (mbgrant) begin
            cnt   <= '0;
            state <= S_SADDR;
          end
        end
        S_SADDR: begin
          mvalid <= 1'b1;
          mwdata <= chunk_dev;
          if (cnt == SDW_LAST) begin
            cnt   <= '0;
            tcnt  <= '0;
            state <= S_WAIT;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WAIT: begin
          // ack wins over an expiry in the same cycle.
          if (ack) begin
            state <= S_ADDR;
          end else if (tcnt == T_LAST) begin
            derr  <= 1'b1;
            state <= S_IDLE;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_ADDR: begin
          mvalid <= 1'b1;
          mwdata <= chunk_mem;
          if (cnt == SMW_LAST) begin
            cnt   <= '0;
            state <= mode ? S_WDATA : S_RDATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_WDATA: begin
          mvalid <= 1'b1;
          mwdata <= chunk_dat;
          if (cnt != DW_LAST) cnt <= cnt + CW'(1);
        end
        S_RDATA: begin
          if (svalid) begin
            if (cnt == DW_LAST) begin
              drdata  <= rd_next;
              drvalid <= 1'b1;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase

      // Next beat goes straight back to SADDR; the bus stays granted.
      if (beat_done) begin
        cnt <= '0;
        if (beat == len) begin
          state <= S_IDLE;
        end else begin
          beat  <= beat + LENW'(1);
          state <= S_SADDR;
        end
      end
    end
  end

  // Captured request fields and the read shift register carry no reset.
  always_ff @(posedge clk) begin
    if (hs) begin
      addr <= daddr;
      len  <= len_in;
    end else if (beat_done && (beat != len)) begin
      addr[SMW-1:0] <= addr[SMW-1:0] + SMW'(1);
    end
    if ((state == S_RDATA) && svalid) rdreg <= rd_next;
  end

endmodule

// File: tb/tb_master_port_burst.sv
// tb_master_port_burst
//   Scoreboard bench for master_port_burst. Stimulus pushes expected beats,
//   read words and errors into queues; monitors pop and compare whenever the
//   DUT presents a serial beat, drvalid or derr. A small slave model answers
//   ack and returns read data. A second instance runs with LANES=4.
module tb_master_port_burst;

  localparam int SDW = 4;
  localparam int SMW = 12;
  localparam int DW  = 8;
  localparam int TO  = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        dvalid, dready, dmode, dwvalid, dwready, drvalid, derr;
  logic        mmode, mvalid, svalid, mbreq, mbgrant, ack;
  logic [15:0] daddr;
  logic [1:0]  dlen;
  logic [7:0]  dwdata, drdata;
  logic [0:0]  mwdata, mrdata;

  logic        dvalid4, dready4, dmode4, dwvalid4, dwready4, drvalid4, derr4;
  logic        mmode4, mvalid4, svalid4, mbreq4, mbgrant4, ack4;
  logic [15:0] daddr4;
  logic [1:0]  dlen4;
  logic [7:0]  dwdata4, drdata4;
  logic [3:0]  mwdata4, mrdata4;

  master_port_burst u_dut (
    .clk(clk), .rst(rst), .dvalid(dvalid), .dready(dready), .daddr(daddr),
    .dmode(dmode), .dlen(dlen), .dwdata(dwdata), .dwvalid(dwvalid),
    .dwready(dwready), .drdata(drdata), .drvalid(drvalid), .derr(derr),
    .mwdata(mwdata), .mrdata(mrdata), .mmode(mmode), .mvalid(mvalid),
    .svalid(svalid), .mbreq(mbreq), .mbgrant(mbgrant), .ack(ack)
  );

  master_port_burst #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .dvalid(dvalid4), .dready(dready4), .daddr(daddr4),
    .dmode(dmode4), .dlen(dlen4), .dwdata(dwdata4), .dwvalid(dwvalid4),
    .dwready(dwready4), .drdata(drdata4), .drvalid(drvalid4), .derr(derr4),
    .mwdata(mwdata4), .mrdata(mrdata4), .mmode(mmode4), .mvalid(mvalid4),
    .svalid(svalid4), .mbreq(mbreq4), .mbgrant(mbgrant4), .ack(ack4)
  );

  typedef struct packed {
    logic        mode;
    logic [3:0]  dev;
    logic [11:0] mem;
    logic [7:0]  data;
  } beat_t;

  beat_t      exp_beat[$];
  logic [7:0] exp_rd[$];
  logic [7:0] slave_rd[$];
  logic [3:0] exp4[$];
  logic [7:0] exp_rd4[$];
  logic [7:0] wq[5];
  int         exp_err;
  int         ack_budget;
  bit         rd_gap;

  int tests = 0;
  int fails = 0;
  int ncycle = 0;
  int mbits = 0;
  int last_dev_cycle = 0;
  int beats_seen = 0;
  int rd_seen = 0;
  int err_seen = 0;
  int ch4_seen = 0;
  int rd4_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor / scoreboard for the default instance.
  logic [23:0] obs = '0;
  beat_t       e_b;
  logic [24:0] act_b;
  logic [7:0]  e_rd;
  always @(negedge clk) begin
    ncycle++;
    if (rst) begin
      mbits = 0;
      obs   = '0;
    end else begin
      if (mvalid) begin
        if (mbits < 24) obs[mbits] = mwdata[0];
        mbits++;
        if (mbits == SDW) last_dev_cycle = ncycle;
        if (mbits == (mmode ? SDW + SMW + DW : SDW + SMW)) begin
          beats_seen++;
          act_b = {mmode, obs[3:0], obs[15:4], mmode ? obs[23:16] : 8'h00};
          if (exp_beat.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_beat: got 0x%0h, expected none", act_b);
          end else begin
            e_b = exp_beat.pop_front();
            chk("beat", 32'(act_b), 32'(e_b));
          end
          mbits = 0;
          obs   = '0;
        end
      end
      if (drvalid) begin
        rd_seen++;
        if (exp_rd.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_drvalid: got 0x%0h, expected none", drdata);
        end else begin
          e_rd = exp_rd.pop_front();
          chk("drdata", 32'(drdata), 32'(e_rd));
        end
      end
      if (derr) begin
        err_seen++;
        chk("derr_expected", 32'(exp_err > 0), 32'd1);
        if (exp_err > 0) exp_err--;
        chk("derr_latency", 32'(ncycle - last_dev_cycle), 32'(TO));
        chk("mbreq_after_err", 32'(mbreq), 32'd0);
        mbits = 0;
        obs   = '0;
      end
    end
  end

  // Slave model for the default instance: ack after the device field,
  // read data LSB first after the memory field.
  int         sbits = 0;
  bit         rd_act = 0;
  bit         gap_done = 0;
  int         rd_k = 0;
  logic [7:0] rd_w = '0;
  always @(negedge clk) begin
    ack    = 1'b0;
    svalid = 1'b0;
    mrdata = '0;
    if (rst) begin
      sbits  = 0;
      rd_act = 0;
    end else begin
      if (derr) sbits = 0;
      if (mvalid) begin
        sbits++;
        if (sbits == SDW && ack_budget != 0) begin
          ack = 1'b1;
          if (ack_budget > 0) ack_budget--;
        end
        if (!mmode && sbits == SDW + SMW) begin
          rd_act   = 1;
          rd_k     = 0;
          gap_done = 0;
          rd_w     = (slave_rd.size() != 0) ? slave_rd.pop_front() : 8'h00;
        end
        if (mmode && sbits == SDW + SMW + DW) sbits = 0;
      end
      if (rd_act) begin
        if (rd_gap && rd_k == 3 && !gap_done) begin
          gap_done = 1;
        end else begin
          svalid    = 1'b1;
          mrdata[0] = rd_w[rd_k];
          rd_k++;
          if (rd_k == 8) begin
            rd_act = 0;
            sbits  = 0;
          end
        end
      end
    end
  end

  // Monitor for the LANES=4 instance.
  logic [3:0] e4;
  logic [7:0] e_rd4;
  always @(negedge clk) begin
    if (!rst) begin
      if (mvalid4) begin
        ch4_seen++;
        if (exp4.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL u4_unexpected_chunk: got 0x%0h, expected none", mwdata4);
        end else begin
          e4 = exp4.pop_front();
          chk("u4_chunk", 32'(mwdata4), 32'(e4));
        end
      end
      if (drvalid4) begin
        rd4_seen++;
        if (exp_rd4.size() != 0) begin
          e_rd4 = exp_rd4.pop_front();
          chk("u4_drdata", 32'(drdata4), 32'(e_rd4));
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    chk({tag, "_dready"},  32'(dready),  32'd1);
    chk({tag, "_dwready"}, 32'(dwready), 32'd0);
    chk({tag, "_mbreq"},   32'(mbreq),   32'd0);
    chk({tag, "_mvalid"},  32'(mvalid),  32'd0);
    chk({tag, "_mwdata"},  32'(mwdata),  32'd0);
    chk({tag, "_mmode"},   32'(mmode),   32'd0);
    chk({tag, "_drvalid"}, 32'(drvalid), 32'd0);
    chk({tag, "_derr"},    32'(derr),    32'd0);
    chk({tag, "_drdata"},  32'(drdata),  32'd0);
  endtask

  // Called at a negedge; returns at a negedge once the request and up to nw
  // write words have been offered.
  task automatic issue(input logic [15:0] a, input logic m, input logic [1:0] l,
                       input int nw, output int loaded);
    int g;
    loaded = 0;
    g = 0;
    while (!dready && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk("dready_before_req", 32'(dready), 32'd1);
    dvalid = 1'b1;
    daddr  = a;
    dmode  = m;
    dlen   = l;
    @(negedge clk);
    dvalid = 1'b0;
    for (int i = 0; i < nw; i++) begin
      g = 0;
      while (!dwready && g < 20) begin
        @(negedge clk);
        g++;
      end
      if (!dwready) break;
      dwvalid = 1'b1;
      dwdata  = wq[i];
      @(negedge clk);
      dwvalid = 1'b0;
      loaded++;
    end
  endtask

  task automatic wait_done(input string tag);
    int g;
    int rem;
    g = 0;
    rem = 1;
    while (rem != 0 && g < 3000) begin
      @(negedge clk);
      rem = exp_beat.size() + exp_rd.size() + exp_err + (dready ? 0 : 1);
      g++;
    end
    chk({tag, "_drained"}, 32'(rem), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ld, g, k, drops, b0;
    rst = 1'b1;
    dvalid = 0; daddr = '0; dmode = 0; dlen = '0; dwdata = '0; dwvalid = 0;
    mbgrant = 1'b1; ack = 0; svalid = 0; mrdata = '0;
    dvalid4 = 0; daddr4 = '0; dmode4 = 0; dlen4 = '0; dwdata4 = '0; dwvalid4 = 0;
    mbgrant4 = 1'b1; ack4 = 1'b1; svalid4 = 0; mrdata4 = '0;
    ack_budget = -1;
    rd_gap = 0;
    exp_err = 0;

    #12;
    check_reset("reset");
    chk("reset_u4_dready", 32'(dready4), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single write: device 0x3, memory 0xA5C, data 0xB6.
    wq[0] = 8'hB6;
    exp_beat.push_back('{1'b1, 4'h3, 12'hA5C, 8'hB6});
    issue(16'h3A5C, 1'b1, 2'd0, 1, ld);
    chk("wr1_loaded", 32'(ld), 32'd1);
    wait_done("wr1");

    // Read burst with memory-field wrap and one svalid gap.
    rd_gap = 1;
    slave_rd.push_back(8'h11); slave_rd.push_back(8'h22);
    slave_rd.push_back(8'h33); slave_rd.push_back(8'h44);
    exp_beat.push_back('{1'b0, 4'h2, 12'hFFE, 8'h00});
    exp_beat.push_back('{1'b0, 4'h2, 12'hFFF, 8'h00});
    exp_beat.push_back('{1'b0, 4'h2, 12'h000, 8'h00});
    exp_beat.push_back('{1'b0, 4'h2, 12'h001, 8'h00});
    exp_rd.push_back(8'h11); exp_rd.push_back(8'h22);
    exp_rd.push_back(8'h33); exp_rd.push_back(8'h44);
    issue(16'h2FFE, 1'b0, 2'd3, 0, ld);
    k = 0; drops = 0; g = 0;
    while (k < 4 && g < 2000) begin
      @(negedge clk);
      if (drvalid) k++;
      if (k < 4 && !mbreq) drops++;
      g++;
    end
    chk("rd_burst_pulses", 32'(k), 32'd4);
    chk("rd_burst_mbreq_drops", 32'(drops), 32'd0);
    wait_done("rd_burst");
    rd_gap = 0;

    // Ack timeout on beat 1 of a 3-beat write.
    ack_budget = 1;
    exp_err = 1;
    wq[0] = 8'hAA; wq[1] = 8'hBB; wq[2] = 8'hCC;
    exp_beat.push_back('{1'b1, 4'h1, 12'h234, 8'hAA});
    issue(16'h1234, 1'b1, 2'd2, 3, ld);
    chk("to_loaded", 32'(ld), 32'd3);
    wait_done("timeout");
    chk("to_err_count", 32'(err_seen), 32'd1);
    ack_budget = -1;
    repeat (60) @(negedge clk);

    // Reset during the memory-address phase of beat 2.
    b0 = beats_seen;
    wq[0] = 8'h5A; wq[1] = 8'hA5;
    exp_beat.push_back('{1'b1, 4'h5, 12'h010, 8'h5A});
    issue(16'h5010, 1'b1, 2'd1, 2, ld);
    g = 0;
    while (!(beats_seen > b0 && mbits >= SDW + 3) && g < 1000) begin
      @(negedge clk);
      g++;
    end
    chk("rst_reached_beat2", 32'(beats_seen - b0), 32'd1);
    rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_no_pending", 32'(exp_beat.size()), 32'd0);
    slave_rd.push_back(8'h96);
    exp_beat.push_back('{1'b0, 4'h7, 12'h123, 8'h00});
    exp_rd.push_back(8'h96);
    issue(16'h7123, 1'b0, 2'd0, 0, ld);
    wait_done("after_rst");

    // Maximum length with delayed grant. The dlen port is two bits wide
    // here, so a requested 7 arrives as 3: exactly four words are taken.
    mbgrant = 1'b0;
    wq[0] = 8'h01; wq[1] = 8'h02; wq[2] = 8'h03; wq[3] = 8'h04; wq[4] = 8'h05;
    exp_beat.push_back('{1'b1, 4'h4, 12'h100, 8'h01});
    exp_beat.push_back('{1'b1, 4'h4, 12'h101, 8'h02});
    exp_beat.push_back('{1'b1, 4'h4, 12'h102, 8'h03});
    exp_beat.push_back('{1'b1, 4'h4, 12'h103, 8'h04});
    issue(16'h4100, 1'b1, 2'b11, 5, ld);
    chk("grant_loaded", 32'(ld), 32'd4);
    chk("grant_dwready_full", 32'(dwready), 32'd0);
    k = 0; drops = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mvalid) k++;
      if (!mbreq) drops++;
    end
    chk("grant_no_mvalid", 32'(k), 32'd0);
    chk("grant_mbreq_held", 32'(drops), 32'd0);
    mbgrant = 1'b1;
    wait_done("grant");

    // LANES=4: device 0x9, memory chunks C,B,A; read 0xC3 as 0x3 then 0xC.
    exp4.push_back(4'h9); exp4.push_back(4'hC);
    exp4.push_back(4'hB); exp4.push_back(4'hA);
    exp_rd4.push_back(8'hC3);
    chk("u4_dready", 32'(dready4), 32'd1);
    dvalid4 = 1'b1; daddr4 = 16'h9ABC; dmode4 = 1'b0; dlen4 = 2'd0;
    @(negedge clk);
    dvalid4 = 1'b0;
    g = 0;
    while (ch4_seen < 4 && g < 200) begin
      @(negedge clk);
      g++;
    end
    chk("u4_chunks", 32'(ch4_seen), 32'd4);
    svalid4 = 1'b1; mrdata4 = 4'h3;
    @(negedge clk);
    mrdata4 = 4'hC;
    @(negedge clk);
    svalid4 = 1'b0; mrdata4 = 4'h0;
    g = 0;
    while (rd4_seen < 1 && g < 50) begin
      @(negedge clk);
      g++;
    end
    chk("u4_drvalid", 32'(rd4_seen), 32'd1);
    chk("u4_leftover", 32'(exp4.size() + exp_rd4.size()), 32'd0);

    repeat (5) @(negedge clk);
    chk("final_leftover", 32'(exp_beat.size() + exp_rd.size() + exp_err), 32'd0);
    chk("final_err_count", 32'(err_seen), 32'd1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
